// File: rtl/exp_3x3_ker_read_cont.sv
// Read-side controller for the double-buffered expand-3x3 kernel RAMs.
// Latency: a word reaches ker_data_o two cycles after its rd_en (RAM + skid capture).
// Backpressure: a 2-entry skid buffer with credit-gated reads; outputs hold while ker_ready_i=0.
//
// Ports:
//   clk_i, rst_i (async, active-high), start_i (1-cycle, samples the config inputs)
//   one_exp3_ker_addr_limit_i / exp3_ker_depth_i / layer_dimension_i : layer config
//   layer_N_ready_i / layer_N_done_o : buffer handshake with the write controller
//   exp_3x3_ram_rd_addr_o / _rd_en_o / exp_3x3_ram_N_rd_data_i : shared RAM read port
//   ker_data_o / ker_valid_o / ker_ready_i / ker_last_depth_o / ker_last_buf_o : kernel stream
//   fire_done_o : every kernel group consumed, held until the next start_i
module exp_3x3_ker_read_cont #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 72,
  parameter int L2_BASE = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [6:0]          one_exp3_ker_addr_limit_i,
  input  logic [5:0]          exp3_ker_depth_i,
  input  logic [6:0]          layer_dimension_i,
  input  logic                layer_1_ready_i,
  output logic                layer_1_done_o,
  input  logic                layer_2_ready_i,
  output logic                layer_2_done_o,
  output logic [ADDR_W-1:0]   exp_3x3_ram_rd_addr_o,
  output logic                exp_3x3_ram_rd_en_o,
  input  logic [DATA_W-1:0]   exp_3x3_ram_1_rd_data_i,
  input  logic [DATA_W-1:0]   exp_3x3_ram_2_rd_data_i,
  input  logic [DATA_W-1:0]   exp_3x3_ram_3_rd_data_i,
  input  logic [DATA_W-1:0]   exp_3x3_ram_4_rd_data_i,
  output logic [4*DATA_W-1:0] ker_data_o,
  output logic                ker_valid_o,
  input  logic                ker_ready_i,
  output logic                ker_last_depth_o,
  output logic                ker_last_buf_o,
  output logic                fire_done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUF,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // One skid entry: flags travel alongside the four concatenated RAM words.
  typedef struct packed {
    logic                lb;
    logic                ld;
    logic [4*DATA_W-1:0] dat;
  } entry_t;

  state_t      r_state;
  logic        r_sel;          // 0 = layer-1 buffer, 1 = layer-2 buffer
  logic [5:0]  r_slice;
  logic [6:0]  r_pass;
  logic [6:0]  r_group;
  logic [5:0]  r_depth;
  logic [6:0]  r_dim;
  logic [6:0]  r_limit;
  logic        r_done1;
  logic        r_done2;
  logic        r_fire_done;

  // Return-path tracking: r_ret_vld marks that RAM data is on the read-data
  // inputs this cycle, with its flags captured at issue time.
  logic        r_ret_vld;
  logic        r_ret_ld;
  logic        r_ret_lb;

  entry_t      r_e0;           // head entry, drives the stream outputs
  entry_t      r_e1;
  logic [1:0]  r_cnt;

  logic              w_pop;
  logic              w_push;
  logic              w_credit;
  logic              w_rd_en;
  logic              w_last_slice;
  logic              w_last_pass;
  logic              w_buf_ready;
  logic [ADDR_W-1:0] w_base;
  entry_t            w_new;

  assign w_pop  = (r_cnt != 2'd0) && ker_ready_i;
  assign w_push = r_ret_vld;

  // Credit counts the word already returning plus skid occupancy after this
  // cycle's pop. Counting the pop lets a read issue in the same cycle a word
  // leaves, which is what sustains one word per cycle with only two entries.
  assign w_credit = ({1'b0, r_cnt} - {2'b00, w_pop} + {2'b00, r_ret_vld}) < 3'd2;

  // start_i suppresses the read so nothing issued in that cycle can return
  // into the freshly cleared skid buffer.
  assign w_rd_en = (r_state == S_READ) && w_credit && !start_i;

  assign w_last_slice = (r_slice == r_depth);
  assign w_last_pass  = (r_pass == r_dim);
  assign w_buf_ready  = r_sel ? layer_2_ready_i : layer_1_ready_i;
  assign w_base       = r_sel ? ADDR_W'(L2_BASE) : '0;

  assign w_new.lb  = r_ret_lb;
  assign w_new.ld  = r_ret_ld;
  assign w_new.dat = {exp_3x3_ram_4_rd_data_i, exp_3x3_ram_3_rd_data_i,
                      exp_3x3_ram_2_rd_data_i, exp_3x3_ram_1_rd_data_i};

  assign exp_3x3_ram_rd_en_o   = w_rd_en;
  assign exp_3x3_ram_rd_addr_o = w_base + ADDR_W'(r_slice);
  assign ker_valid_o           = (r_cnt != 2'd0);
  assign ker_data_o            = r_e0.dat;
  assign ker_last_depth_o      = ker_valid_o && r_e0.ld;
  assign ker_last_buf_o        = ker_valid_o && r_e0.lb;
  assign layer_1_done_o        = r_done1;
  assign layer_2_done_o        = r_done2;
  assign fire_done_o           = r_fire_done;

  // Control FSM with address counters and registered done pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_slice     <= '0;
      r_pass      <= '0;
      r_group     <= '0;
      r_depth     <= '0;
      r_dim       <= '0;
      r_limit     <= '0;
      r_done1     <= 1'b0;
      r_done2     <= 1'b0;
      r_fire_done <= 1'b0;
      r_ret_vld   <= 1'b0;
      r_ret_ld    <= 1'b0;
      r_ret_lb    <= 1'b0;
    end else if (start_i) begin
      r_state     <= (one_exp3_ker_addr_limit_i == 7'd0) ? S_DONE : S_WAIT_BUF;
      r_fire_done <= (one_exp3_ker_addr_limit_i == 7'd0);
      r_sel       <= 1'b0;
      r_slice     <= '0;
      r_pass      <= '0;
      r_group     <= '0;
      r_depth     <= exp3_ker_depth_i;
      r_dim       <= layer_dimension_i;
      r_limit     <= one_exp3_ker_addr_limit_i;
      r_done1     <= 1'b0;
      r_done2     <= 1'b0;
      r_ret_vld   <= 1'b0;
      r_ret_ld    <= 1'b0;
      r_ret_lb    <= 1'b0;
    end else begin
      r_done1   <= 1'b0;
      r_done2   <= 1'b0;
      r_ret_vld <= w_rd_en;
      r_ret_ld  <= w_last_slice;
      r_ret_lb  <= w_last_slice && w_last_pass;
      case (r_state)
        S_WAIT_BUF: begin
          if (w_buf_ready) begin
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (w_rd_en) begin
            if (w_last_slice) begin
              r_slice <= '0;
              if (w_last_pass) begin
                r_pass  <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_pass <= r_pass + 7'd1;
              end
            end else begin
              r_slice <= r_slice + 6'd1;
            end
          end
        end
        S_DRAIN: begin
          // Release only once every word of this buffer has been handed off.
          if (!r_ret_vld && (r_cnt == 2'd0)) begin
            r_done1 <= !r_sel;
            r_done2 <= r_sel;
            r_sel   <= !r_sel;
            r_group <= r_group + 7'd1;
            if (r_group == (r_limit - 7'd1)) begin
              r_state     <= S_DONE;
              r_fire_done <= 1'b1;
            end else begin
              r_state <= S_WAIT_BUF;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Two-entry skid buffer; r_e0 is always the oldest word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= 2'd0;
    end else if (start_i) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= w_new;
          else               r_e1 <= w_new;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_e0 <= w_new;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= w_new;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_3x3_ker_read_cont.sv
module tb_exp_3x3_ker_read_cont;

  logic         clk;
  logic         rst;
  logic         start;
  logic [6:0]   lim_i;
  logic [5:0]   dep_i;
  logic [6:0]   dim_i;
  logic         rdy1;
  logic         rdy2;
  logic         done1;
  logic         done2;
  logic [6:0]   rd_addr;
  logic         rd_en;
  logic [71:0]  rd1, rd2, rd3, rd4;
  logic [287:0] kdata;
  logic         kvalid;
  logic         kready;
  logic         lastd;
  logic         lastb;
  logic         fdone;

  logic [71:0]  mem [0:3][0:127];
  int           cyc;
  int           n_vec;
  int           n_bad;

  exp_3x3_ker_read_cont dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .start_i                   (start),
    .one_exp3_ker_addr_limit_i (lim_i),
    .exp3_ker_depth_i          (dep_i),
    .layer_dimension_i         (dim_i),
    .layer_1_ready_i           (rdy1),
    .layer_1_done_o            (done1),
    .layer_2_ready_i           (rdy2),
    .layer_2_done_o            (done2),
    .exp_3x3_ram_rd_addr_o     (rd_addr),
    .exp_3x3_ram_rd_en_o       (rd_en),
    .exp_3x3_ram_1_rd_data_i   (rd1),
    .exp_3x3_ram_2_rd_data_i   (rd2),
    .exp_3x3_ram_3_rd_data_i   (rd3),
    .exp_3x3_ram_4_rd_data_i   (rd4),
    .ker_data_o                (kdata),
    .ker_valid_o               (kvalid),
    .ker_ready_i               (kready),
    .ker_last_depth_o          (lastd),
    .ker_last_buf_o            (lastb),
    .fire_done_o               (fdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      rd1 <= mem[0][rd_addr];
      rd2 <= mem[1][rd_addr];
      rd3 <= mem[2][rd_addr];
      rd4 <= mem[3][rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 128; a++)
        mem[k][a] = {8'($urandom), $urandom, $urandom};
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_addr"},  rd_addr, 0);
    chk({tag, "_vld"},   kvalid, 0);
    chk({tag, "_data"},  kdata, 0);
    chk({tag, "_lastd"}, lastd, 0);
    chk({tag, "_lastb"}, lastb, 0);
    chk({tag, "_done1"}, done1, 0);
    chk({tag, "_done2"}, done2, 0);
    chk({tag, "_fdone"}, fdone, 0);
  endtask

  // rmode: 0 = always ready, 1 = toggle 1,0,..., 2 = random.
  // r2d: layer-2 ready held low for this many cycles after start.
  // abort_at: return as soon as a read to this address is seen (-1 = never).
  task automatic run_fire(input int dep, input int dim, input int lim, input int rmode,
                          input int r2d, input int abort_at, output bit aborted);
    logic [289:0] exp_w[$];
    int           exp_a[$];
    logic [289:0] w, pw;
    int           wpb, acc, nd1, nd2, nrd, first, t0, ea;
    bit           pv;
    aborted = 0;
    wpb = (dep + 1) * (dim + 1);
    // Expected stream: each buffer read dim+1 times, depth slices in order.
    for (int b = 0; b < lim; b++)
      for (int p = 0; p <= dim; p++)
        for (int s = 0; s <= dep; s++) begin
          ea = ((b % 2) ? 64 : 0) + s;
          exp_a.push_back(ea);
          exp_w.push_back({(s == dep) && (p == dim), s == dep,
                           mem[3][ea], mem[2][ea], mem[1][ea], mem[0][ea]});
        end
    acc = 0; nd1 = 0; nd2 = 0; nrd = 0; first = 0; pv = 0; pw = '0;
    @(negedge clk);
    lim_i = 7'(lim); dep_i = 6'(dep); dim_i = 7'(dim);
    start = 1'b1; kready = 1'b0; rdy2 = (r2d == 0);
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    #1;
    chk("start_vld", kvalid, 0);
    chk("start_fd", fdone, lim == 0);
    forever begin
      if (pv) begin
        chk("stall_vld", kvalid, 1);
        chk("stall_word", {lastb, lastd, kdata}, pw);
      end
      if (rd_en) begin
        if (abort_at == int'(rd_addr)) begin
          aborted = 1;
          return;
        end
        nrd++;
        if (exp_a.size() == 0) chk("extra_rd", rd_addr, 300'h1ff);
        else chk("rd_addr", rd_addr, exp_a.pop_front());
        if (rd_addr >= 7'd64) chk("l2_gate", rdy2, 1);
      end
      if (kvalid && kready) begin
        if (rmode == 0 && (acc % wpb) == 0) first = cyc;
        if (rmode == 0 && (acc % wpb) == wpb - 1) chk("thruput", cyc - first, wpb - 1);
        acc++;
        w = exp_w.size() ? exp_w.pop_front() : '1;
        chk("word", {lastb, lastd, kdata}, w);
      end
      if (done1 || done2) begin
        chk("done_at", acc, (nd1 + nd2 + 1) * wpb);
        chk("done_sel", {done1, done2}, ((nd1 + nd2) % 2) ? 2'b01 : 2'b10);
        if (done1) nd1++;
        if (done2) nd2++;
      end
      pv = kvalid && !kready;
      pw = {lastb, lastd, kdata};
      if (fdone) break;
      if (cyc - t0 > lim * wpb * 6 + 200) begin
        chk("timeout_fdone", fdone, 1);
        break;
      end
      @(negedge clk);
      case (rmode)
        0:       kready = 1'b1;
        1:       kready = ~kready;
        default: kready = ($urandom_range(0, 9) < 6);
      endcase
      rdy2 = (cyc - t0 >= r2d);
      #1;
    end
    chk("n_words", acc, lim * wpb);
    chk("n_reads", nrd, lim * wpb);
    chk("n_done1", nd1, (lim + 1) / 2);
    chk("n_done2", nd2, lim / 2);
    if (lim == 0) chk("fd_latency", (cyc - t0) <= 2, 1);
  endtask

  initial begin
    bit ab;
    int nrd, ndn;
    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; lim_i = '0; dep_i = '0; dim_i = '0;
    rdy1 = 1'b1; rdy2 = 1'b1; kready = 1'b0;
    rd1 = '0; rd2 = '0; rd3 = '0; rd4 = '0;
    fill_mem();
    #1;
    check_zero("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases from the block's intended use.
    run_fire(2, 1, 2, 0, 0, -1, ab);
    run_fire(2, 1, 2, 1, 0, -1, ab);
    run_fire(2, 1, 2, 0, 50, -1, ab);

    // start_i mid-read: stream restarts cleanly at address 0.
    run_fire(2, 1, 2, 0, 0, 65, ab);
    chk("abort_hit", ab, 1);
    run_fire(2, 1, 2, 2, 0, -1, ab);

    // No kernel groups: immediate completion, no reads.
    run_fire(0, 0, 0, 0, 0, -1, ab);

    // Randomized configurations and ready patterns.
    for (int i = 0; i < 8; i++) begin
      fill_mem();
      run_fire($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(1, 5),
               $urandom_range(0, 2), $urandom_range(0, 20), -1, ab);
    end

    // Deepest kernel, reaching address 127.
    fill_mem();
    run_fire(63, 1, 3, 2, 0, -1, ab);

    // Asynchronous reset in the middle of a read.
    run_fire(3, 2, 2, 0, 0, 1, ab);
    chk("rst_abort_hit", ab, 1);
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    nrd = 0; ndn = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (rd_en) nrd++;
      if (done1 || done2) ndn++;
    end
    chk("post_rst_rd", nrd, 0);
    chk("post_rst_done", ndn, 0);
    run_fire(3, 2, 2, 2, 0, -1, ab);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
